// File: rtl/uart_tx_arbiter_pkg.sv
// Shared configuration and types for the UART transmit arbiter.
// Holds the core count, arbiter state encoding and the newline byte.
package taiga_config;
   localparam int NUM_CPUS = 2;
endpackage

package taiga_types;
   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   localparam logic [7:0] UART_NEWLINE = 8'h0A;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Per-core write ports and the shared transmit sink of the arbiter.
// slave: the arbiter side; master: the cores and the sink.
interface uart_tx_arbiter_if #(
   parameter int NUM_PORTS = taiga_config::NUM_CPUS,
   parameter int SRC_W     = $clog2(NUM_PORTS)
);
   logic [NUM_PORTS-1:0]      wr_valid;
   logic [NUM_PORTS-1:0][7:0] wr_data;
   logic [NUM_PORTS-1:0]      wr_ready;
   logic                      tx_valid;
   logic [7:0]                tx_data;
   logic [SRC_W-1:0]          tx_src;
   logic                      tx_ready;
   logic                      locked;

   modport slave (
      input  wr_valid, wr_data, tx_ready,
      output wr_ready, tx_valid, tx_data, tx_src, locked
   );

   modport master (
      output wr_valid, wr_data, tx_ready,
      input  wr_ready, tx_valid, tx_data, tx_src, locked
   );
endinterface

// File: rtl/uart_tx_arbiter_fifo.sv
// Single-port byte FIFO buffering one core's console output.
// Pointers wrap naturally because DEPTH is a power of two.
module uart_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic       full,
   output logic       empty,
   output logic [7:0] head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Next storage, pointer and occupancy values.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset empties the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sink between several cores.
// A grant is held until a newline, the hold limit or an idle timeout.
module uart_tx_arbiter
   import taiga_types::*;
#(
   parameter int NUM_PORTS    = taiga_config::NUM_CPUS,
   parameter int FIFO_DEPTH   = 8,
   parameter int MAX_HOLD     = 64,
   parameter int IDLE_TIMEOUT = 256
) (
   input logic             clk,
   input logic             rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int SRC_W = $clog2(NUM_PORTS);
   localparam int HW    = $clog2(MAX_HOLD + 1);
   localparam int IW    = $clog2(IDLE_TIMEOUT + 1);

   logic [NUM_PORTS-1:0] full, empty, pop;
   logic [7:0]           head [NUM_PORTS];

   arb_state_t       state_q;
   logic [SRC_W-1:0] owner_q, last_owner_q;
   logic [HW-1:0]    hold_cnt_q;
   logic [IW-1:0]    idle_cnt_q;

   logic             grant_found;
   logic [SRC_W-1:0] grant_idx;
   logic             owner_empty, accept;
   logic [7:0]       owner_head;
   logic [HW-1:0]    hold_inc;
   logic [IW-1:0]    idle_inc;
   logic             hold_hit, nl_hit, idle_hit, idle_sat;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
      uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (bus.wr_valid[g] & ~full[g]),
         .pop   (pop[g]),
         .din   (bus.wr_data[g]),
         .full  (full[g]),
         .empty (empty[g]),
         .head  (head[g])
      );
   end

   assign bus.wr_ready = ~full;

   assign owner_empty = empty[owner_q];
   assign owner_head  = head[owner_q];
   assign accept      = bus.tx_valid & bus.tx_ready;
   assign pop         = accept ? (NUM_PORTS'(1) << owner_q) : '0;

   assign hold_inc = hold_cnt_q + 1'b1;
   assign idle_inc = idle_cnt_q + 1'b1;
   assign hold_hit = (hold_inc == HW'(MAX_HOLD));
   assign nl_hit   = (owner_head == UART_NEWLINE);
   assign idle_sat = (idle_cnt_q == IW'(IDLE_TIMEOUT));
   assign idle_hit = owner_empty & (idle_inc == IW'(IDLE_TIMEOUT));

   assign bus.locked   = (state_q == ARB_LOCKED);
   assign bus.tx_valid = bus.locked & ~owner_empty;
   assign bus.tx_data  = bus.locked ? owner_head : 8'h00;
   assign bus.tx_src   = bus.locked ? owner_q : last_owner_q;

   // First non-empty port after the previous owner, with wrap.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_owner_q;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         if (!empty[(int'(last_owner_q) + k) % NUM_PORTS]) begin
            grant_found = 1'b1;
            grant_idx   = SRC_W'((int'(last_owner_q) + k) % NUM_PORTS);
         end
      end
   end

   // Grant FSM with hold and idle counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         owner_q      <= '0;
         last_owner_q <= SRC_W'(NUM_PORTS - 1);
         hold_cnt_q   <= '0;
         idle_cnt_q   <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (grant_found) begin
                  state_q    <= ARB_LOCKED;
                  owner_q    <= grant_idx;
                  hold_cnt_q <= '0;
                  idle_cnt_q <= '0;
               end
            end
            ARB_LOCKED: begin
               if (accept) begin
                  hold_cnt_q <= hold_inc;
                  idle_cnt_q <= '0;
                  if (nl_hit || hold_hit) begin
                     state_q      <= ARB_IDLE;
                     last_owner_q <= owner_q;
                  end
               end else if (owner_empty) begin
                  if (!idle_sat) idle_cnt_q <= idle_inc;
                  if (idle_hit) begin
                     state_q      <= ARB_IDLE;
                     last_owner_q <= owner_q;
                  end
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end
endmodule
